// File: rtl/mgr_noc_locl_arb_if.sv
// mgr_noc_locl_arb_if: source-side and NoC-side signal bundle for the local manager arbiter
// master: arbiter view (sources and NoC ready in; source ready, output beat, error flags out)
// slave : environment view (directions reversed)
interface mgr_noc_locl_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int TYPE_W = 2,
  parameter int PTYPE_W = 2,
  parameter int DEST_W = 2
);
  localparam int CW = $clog2(NUM_CH);
  logic [NUM_CH-1:0] src__arb__valid;
  logic [2*NUM_CH-1:0] src__arb__cntl;
  logic [NUM_CH-1:0] arb__src__ready;
  logic [TYPE_W*NUM_CH-1:0] src__arb__type;
  logic [PTYPE_W*NUM_CH-1:0] src__arb__ptype;
  logic [DEST_W*NUM_CH-1:0] src__arb__desttype;
  logic [NUM_CH-1:0] src__arb__pvalid;
  logic [DATA_W*NUM_CH-1:0] src__arb__data;
  logic locl__noc__dp_valid;
  logic [1:0] locl__noc__dp_cntl;
  logic noc__locl__dp_ready;
  logic [TYPE_W-1:0] locl__noc__dp_type;
  logic [PTYPE_W-1:0] locl__noc__dp_ptype;
  logic [DEST_W-1:0] locl__noc__dp_desttype;
  logic locl__noc__dp_pvalid;
  logic [DATA_W-1:0] locl__noc__dp_data;
  logic [CW-1:0] locl__noc__dp_chan;
  logic [NUM_CH-1:0] arb__sys__err;
  modport master (
    input src__arb__valid, src__arb__cntl, src__arb__type, src__arb__ptype, src__arb__desttype,
          src__arb__pvalid, src__arb__data, noc__locl__dp_ready,
    output arb__src__ready, locl__noc__dp_valid, locl__noc__dp_cntl, locl__noc__dp_type,
           locl__noc__dp_ptype, locl__noc__dp_desttype, locl__noc__dp_pvalid, locl__noc__dp_data,
           locl__noc__dp_chan, arb__sys__err
  );
  modport slave (
    output src__arb__valid, src__arb__cntl, src__arb__type, src__arb__ptype, src__arb__desttype,
           src__arb__pvalid, src__arb__data, noc__locl__dp_ready,
    input arb__src__ready, locl__noc__dp_valid, locl__noc__dp_cntl, locl__noc__dp_type,
          locl__noc__dp_ptype, locl__noc__dp_desttype, locl__noc__dp_pvalid, locl__noc__dp_data,
          locl__noc__dp_chan, arb__sys__err
  );
endinterface

// File: rtl/mgr_noc_locl_arb.sv
// mgr_noc_locl_arb: packet-atomic round-robin arbiter from NUM_CH local sources onto the NoC local ingress port
// Ports: clk, reset_poweron (async, active-high), bus (mgr_noc_locl_arb_if.master):
//   per-channel source beats in with registered ready out, one registered output beat with
//   valid/ready handshake and source channel, sticky per-channel protocol-error flags.
// Option: MGR_NOC_LOCL_ARB_PRIORITY_EN gives channel 0 strict priority at packet boundaries.
module mgr_noc_locl_arb #(
  parameter int NUM_CH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W = 64,
  parameter int TYPE_W = 2,
  parameter int PTYPE_W = 2,
  parameter int DEST_W = 2
) (
  input logic clk,
  input logic reset_poweron,
  mgr_noc_locl_arb_if.master bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = 3 + TYPE_W + PTYPE_W + DEST_W + DATA_W;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [CW-1:0] owner, last_grant, win, sel, j;
  logic [BW-1:0] head [NUM_CH];
  logic [NUM_CH-1:0] push, pop, empty, elig, bad, rdy, err_set;
  logic [1:0] hc;
  logic found, ld, xfer, conv;
  // Beat layout: {cntl, type, ptype, desttype, pvalid, data}; cntl bit 0 marks a packet start
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [BW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0] cnt, nxt;
    logic r;
    assign nxt = cnt + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    assign rdy[i] = r;
    assign push[i] = bus.src__arb__valid[i] & r;
    assign empty[i] = cnt == '0;
    assign head[i] = mem[rd];
    always_ff @(posedge clk)
      if (push[i]) mem[wr] <= {bus.src__arb__cntl[2*i+:2], bus.src__arb__type[TYPE_W*i+:TYPE_W],
                               bus.src__arb__ptype[PTYPE_W*i+:PTYPE_W], bus.src__arb__desttype[DEST_W*i+:DEST_W],
                               bus.src__arb__pvalid[i], bus.src__arb__data[DATA_W*i+:DATA_W]};
    // Ready is the registered complement of full, so it reopens the cycle after a pop
    always_ff @(posedge clk or posedge reset_poweron)
      if (reset_poweron) begin
        wr <= '0;
        rd <= '0;
        cnt <= '0;
        r <= 1'b0;
      end else begin
        wr <= wr + AW'(push[i]);
        rd <= rd + AW'(pop[i]);
        cnt <= nxt;
        r <= nxt != (AW+1)'(FIFO_DEPTH);
      end
  end
  assign bus.arb__src__ready = rdy;
  always_comb begin
    found = 1'b0;
    win = '0;
    j = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = !empty[i] & head[i][BW-2];
      bad[i] = !empty[i] & !head[i][BW-2];
    end
`ifdef MGR_NOC_LOCL_ARB_PRIORITY_EN
    found = elig[0];
`endif
    for (int k = 1; k <= NUM_CH; k++) begin
      j = CW'((int'(last_grant) + k) % NUM_CH);
      if (!found && elig[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  assign sel = state == LOCKED ? owner : win;
  assign hc = head[sel][BW-1 -: 2];
  assign ld = !bus.locl__noc__dp_valid | bus.noc__locl__dp_ready;
  assign xfer = ld & (state == LOCKED ? !empty[sel] : found);
  // A packet start inside a locked packet closes it as EOM; the head stays queued to restart later
  assign conv = state == LOCKED & hc[0];
  // Misplaced MOM/EOM heads are discarded in IDLE independently of the output slot
  always_comb begin
    pop = state == IDLE ? bad : '0;
    err_set = pop;
    if (xfer & !conv) pop[sel] = 1'b1;
    if (xfer & conv) err_set[sel] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset_poweron)
    if (reset_poweron) begin
      state <= IDLE;
      owner <= '0;
      last_grant <= CW'(NUM_CH - 1);
      bus.arb__sys__err <= '0;
      bus.locl__noc__dp_valid <= 1'b0;
      bus.locl__noc__dp_cntl <= '0;
      bus.locl__noc__dp_chan <= '0;
      {bus.locl__noc__dp_type, bus.locl__noc__dp_ptype, bus.locl__noc__dp_desttype,
       bus.locl__noc__dp_pvalid, bus.locl__noc__dp_data} <= '0;
    end else begin
      bus.arb__sys__err <= bus.arb__sys__err | err_set;
      if (ld) bus.locl__noc__dp_valid <= xfer;
      if (xfer) begin
        bus.locl__noc__dp_cntl <= conv ? 2'b10 : hc;
        bus.locl__noc__dp_chan <= sel;
        {bus.locl__noc__dp_type, bus.locl__noc__dp_ptype, bus.locl__noc__dp_desttype,
         bus.locl__noc__dp_pvalid, bus.locl__noc__dp_data} <= head[sel][BW-3:0];
        if (state == IDLE) begin
          last_grant <= sel;
          owner <= sel;
          state <= hc == 2'b01 ? LOCKED : IDLE;
        end else if (|hc) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_mgr_noc_locl_arb.sv
// tb_mgr_noc_locl_arb: directed self-checking bench for mgr_noc_locl_arb (NUM_CH=4, FIFO_DEPTH=4)
module tb_mgr_noc_locl_arb;
  logic clk = 1'b0;
  logic reset_poweron = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [65:0] sq [4][$];
  logic [74:0] exp_q [$];
  always #5 clk = ~clk;
  mgr_noc_locl_arb_if #(.NUM_CH(4), .DATA_W(64), .TYPE_W(2), .PTYPE_W(2), .DEST_W(2)) bus ();
  mgr_noc_locl_arb #(.NUM_CH(4), .FIFO_DEPTH(4), .DATA_W(64), .TYPE_W(2), .PTYPE_W(2), .DEST_W(2)) dut (
    .clk(clk), .reset_poweron(reset_poweron), .bus(bus)
  );
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic logic [74:0] beat(input int ch, input logic [1:0] c, input logic [63:0] d);
    return {2'(ch), c, 2'(ch), d[1:0], d[3:2], d[4], d};
  endfunction
  function automatic logic [74:0] obs_beat();
    return {bus.locl__noc__dp_chan, bus.locl__noc__dp_cntl, bus.locl__noc__dp_type, bus.locl__noc__dp_ptype,
            bus.locl__noc__dp_desttype, bus.locl__noc__dp_pvalid, bus.locl__noc__dp_data};
  endfunction
  task automatic send(input int ch, input logic [1:0] c, input logic [63:0] d, input bit expect_out);
    sq[ch].push_back({c, d});
    if (expect_out) exp_q.push_back(beat(ch, c, d));
  endtask
  function automatic bit pending();
    return exp_q.size() > 0 || sq[0].size() > 0 || sq[1].size() > 0 || sq[2].size() > 0 || sq[3].size() > 0;
  endfunction
  // One cycle: present queued source beats and NoC ready, check the output against the next
  // expected beat, retire whatever the coming edge accepts, then advance past the edge.
  task automatic cyc(input bit rdy);
    for (int c = 0; c < 4; c++) begin
      bus.src__arb__valid[c] = sq[c].size() > 0;
      if (sq[c].size() > 0) begin
        bus.src__arb__cntl[2*c+:2] = sq[c][0][65:64];
        bus.src__arb__data[64*c+:64] = sq[c][0][63:0];
        bus.src__arb__type[2*c+:2] = 2'(c);
        bus.src__arb__ptype[2*c+:2] = sq[c][0][1:0];
        bus.src__arb__desttype[2*c+:2] = sq[c][0][3:2];
        bus.src__arb__pvalid[c] = sq[c][0][4];
      end
    end
    bus.noc__locl__dp_ready = rdy;
    if (exp_q.size() == 0) chk("idle_out", 80'(bus.locl__noc__dp_valid), 80'(0));
    else if (bus.locl__noc__dp_valid) begin
      chk("beat", 80'(obs_beat()), 80'(exp_q[0]));
      if (rdy) void'(exp_q.pop_front());
    end
    for (int c = 0; c < 4; c++)
      if (bus.src__arb__valid[c] && bus.arb__src__ready[c]) void'(sq[c].pop_front());
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string tag, input int max, input bit tog);
    bit r = 1'b1;
    for (int n = 0; n < max && pending(); n++) begin
      cyc(r);
      if (tog) r = !r;
    end
    chk(tag, 80'(exp_q.size()), 80'(0));
  endtask
  initial begin
    bus.src__arb__valid = '0;
    bus.src__arb__cntl = '0;
    bus.src__arb__type = '0;
    bus.src__arb__ptype = '0;
    bus.src__arb__desttype = '0;
    bus.src__arb__pvalid = '0;
    bus.src__arb__data = '0;
    bus.noc__locl__dp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_poweron = 1'b0;
    chk("rst_valid", 80'(bus.locl__noc__dp_valid), 80'(0));
    chk("rst_fields", 80'(obs_beat()), 80'(0));
    chk("rst_err", 80'(bus.arb__sys__err), 80'(0));
    @(posedge clk);
    #1;
    chk("rst_ready", 80'(bus.arb__src__ready), 80'(4'b1111));
    send(2, 2'b01, 64'hA, 1);
    send(2, 2'b00, 64'hB, 1);
    send(2, 2'b10, 64'hC, 1);
    cyc(1);
    chk("lat_pre", 80'(bus.locl__noc__dp_valid), 80'(0));
    cyc(1);
    chk("lat_first", 80'(bus.locl__noc__dp_valid), 80'(1));
    repeat (3) cyc(1);
    chk("single_done", 80'(exp_q.size()), 80'(0));
    send(2, 2'b11, 64'h40, 1);
    send(2, 2'b11, 64'h41, 1);
    send(2, 2'b01, 64'h42, 1);
    send(2, 2'b10, 64'h43, 1);
    repeat (6) cyc(1);
    chk("b2b_done", 80'(exp_q.size()), 80'(0));
    send(0, 2'b01, 64'h10, 1);
    send(0, 2'b00, 64'h11, 1);
    send(0, 2'b10, 64'h12, 1);
    send(1, 2'b01, 64'h20, 0);
    send(1, 2'b00, 64'h21, 0);
    send(1, 2'b10, 64'h22, 0);
    exp_q.push_back(beat(1, 2'b01, 64'h20));
    exp_q.push_back(beat(1, 2'b00, 64'h21));
    exp_q.push_back(beat(1, 2'b10, 64'h22));
    drain("atomic_done", 40, 1);
    send(3, 2'b01, 64'h50, 1);
    for (int k = 1; k < 5; k++) send(3, 2'b00, 64'h50 + 64'(k), 1);
    send(3, 2'b10, 64'h55, 1);
    repeat (8) cyc(0);
    chk("bp_ready3", 80'(bus.arb__src__ready[3]), 80'(0));
    chk("bp_pending", 80'(sq[3].size()), 80'(1));
    chk("bp_head", 80'(obs_beat()), 80'(beat(3, 2'b01, 64'h50)));
    drain("bp_done", 20, 0);
    send(1, 2'b10, 64'h55, 0);
    repeat (4) cyc(1);
    chk("orphan_err", 80'(bus.arb__sys__err), 80'(4'b0010));
    send(0, 2'b01, 64'h30, 1);
    send(0, 2'b01, 64'h31, 0);
    send(0, 2'b10, 64'h32, 0);
    exp_q.push_back(beat(0, 2'b10, 64'h31));
    exp_q.push_back(beat(0, 2'b01, 64'h31));
    exp_q.push_back(beat(0, 2'b10, 64'h32));
    drain("somsom_done", 20, 0);
    chk("somsom_err", 80'(bus.arb__sys__err), 80'(4'b0011));
    send(3, 2'b01, 64'h60, 1);
    send(3, 2'b00, 64'h61, 1);
    send(3, 2'b00, 64'h62, 1);
    send(3, 2'b10, 64'h63, 1);
    send(3, 2'b01, 64'h64, 0);
    send(3, 2'b10, 64'h65, 0);
    repeat (2) cyc(1);
    send(0, 2'b11, 64'h70, 1);
    send(0, 2'b11, 64'h71, 0);
`ifdef MGR_NOC_LOCL_ARB_PRIORITY_EN
    exp_q.push_back(beat(0, 2'b11, 64'h71));
    exp_q.push_back(beat(3, 2'b01, 64'h64));
    exp_q.push_back(beat(3, 2'b10, 64'h65));
`else
    exp_q.push_back(beat(3, 2'b01, 64'h64));
    exp_q.push_back(beat(3, 2'b10, 64'h65));
    exp_q.push_back(beat(0, 2'b11, 64'h71));
`endif
    drain("prio_done", 30, 0);
    send(1, 2'b01, 64'h80, 1);
    send(1, 2'b00, 64'h81, 0);
    repeat (3) cyc(0);
    chk("mp_valid", 80'(bus.locl__noc__dp_valid), 80'(1));
    reset_poweron = 1'b1;
    #1;
    chk("mp_drop", 80'(bus.locl__noc__dp_valid), 80'(0));
    chk("mp_err", 80'(bus.arb__sys__err), 80'(0));
    for (int c = 0; c < 4; c++) sq[c].delete();
    exp_q.delete();
    bus.src__arb__valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_poweron = 1'b0;
    @(posedge clk);
    #1;
    chk("mp_ready", 80'(bus.arb__src__ready), 80'(4'b1111));
    repeat (4) cyc(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
